// File: rtl/mixer_gain_ramp_pkg.sv
// mixer_gain_ramp_pkg
// Shared constants for the mixer gain ramp block: channel count, index
// width, gain width and the voice channel indices.
package mixer_gain_ramp_pkg;

  localparam int NUM_CH = 6;
  localparam int CH_W   = 3;
  localparam int GAIN_W = 8;
  localparam int STEP_W = 4;

  localparam logic [CH_W-1:0] CH_SQUARE    = 3'd0;
  localparam logic [CH_W-1:0] CH_SAWTOOTH  = 3'd1;
  localparam logic [CH_W-1:0] CH_TRIANGLE  = 3'd2;
  localparam logic [CH_W-1:0] CH_SINE      = 3'd3;
  localparam logic [CH_W-1:0] CH_NOISE     = 3'd4;
  localparam logic [CH_W-1:0] CH_WAVETABLE = 3'd5;

  // True when a channel index addresses a real voice (6 and 7 are unused).
  function automatic logic ch_valid(input logic [CH_W-1:0] ch);
    return (ch <= CH_WAVETABLE);
  endfunction

endpackage

// File: rtl/gain_ramp_step.sv
// gain_ramp_step
// Combinational single-step gain slew: moves current toward target by at
// most step, landing exactly on target without overshoot or wrap.
// Ports:
//   current - present gain of the serviced channel
//   target  - requested gain of the serviced channel
//   step    - slew per service; 0 jumps straight to target
//   next    - gain after this service
module gain_ramp_step
  import mixer_gain_ramp_pkg::*;
(
  input  logic [GAIN_W-1:0] current,
  input  logic [GAIN_W-1:0] target,
  input  logic [STEP_W-1:0] step,
  output logic [GAIN_W-1:0] next
);

  // 9-bit intermediates: bit 8 of sum flags an overflow past 255, bit 8 of
  // diff flags a borrow below 0; both are clamped to target.
  logic [GAIN_W:0] sum9;
  logic [GAIN_W:0] diff9;
  logic [GAIN_W:0] tgt9;

  assign tgt9  = {1'b0, target};
  assign sum9  = {1'b0, current} + {{(GAIN_W+1-STEP_W){1'b0}}, step};
  assign diff9 = {1'b0, current} - {{(GAIN_W+1-STEP_W){1'b0}}, step};

  always_comb begin
    next = current;
    if (step == '0) begin
      next = target;
    end else if (current < target) begin
      next = (sum9 > tgt9) ? target : sum9[GAIN_W-1:0];
    end else if (current > target) begin
      next = (diff9[GAIN_W] || (diff9 < tgt9)) ? target : diff9[GAIN_W-1:0];
    end
  end

endmodule

// File: rtl/mixer_gain_ramp.sv
// mixer_gain_ramp
// Per-voice gain slewing for the six mixer channels. A round-robin pointer
// services one channel per tick, moving its current gain toward the target
// written by the register file. kill mutes everything at once.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   tick      - one-cycle service strobe at ramp rate
//   wr_en     - target write strobe
//   wr_ch     - target channel (0..5; 6/7 ignored)
//   wr_data   - new target gain
//   ramp_step - gain delta per service, 0 = jump
//   kill      - emergency mute, clears all targets and gains
//   gain_out  - current gains, channel n in [8n+7:8n]
//   busy      - any channel still ramping
module mixer_gain_ramp
  import mixer_gain_ramp_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [GAIN_W-1:0]        wr_data,
  input  logic [STEP_W-1:0]        ramp_step,
  input  logic                     kill,
  output logic [NUM_CH*GAIN_W-1:0] gain_out,
  output logic                     busy
);

  logic [GAIN_W-1:0] target_q  [NUM_CH];
  logic [GAIN_W-1:0] current_q [NUM_CH];
  logic [CH_W-1:0]   ptr_q;

  logic [GAIN_W-1:0] sel_cur;
  logic [GAIN_W-1:0] sel_tgt;
  logic [GAIN_W-1:0] svc_next;
  logic [CH_W-1:0]   ptr_nxt;

  // The pointer never leaves 0..5, so the unmatched case default is unused.
  always_comb begin
    sel_cur = '0;
    sel_tgt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ptr_q == CH_W'(i)) begin
        sel_cur = current_q[i];
        sel_tgt = target_q[i];
      end
    end
  end

  gain_ramp_step u_step (
    .current (sel_cur),
    .target  (sel_tgt),
    .step    (ramp_step),
    .next    (svc_next)
  );

  assign ptr_nxt = (ptr_q == CH_WAVETABLE) ? CH_SQUARE : ptr_q + CH_W'(1);

  // The service reads the registered target, so a write landing on the
  // serviced channel in the same cycle only takes effect on its next slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i]  <= '0;
        current_q[i] <= '0;
      end
    end else if (kill) begin
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i]  <= '0;
        current_q[i] <= '0;
      end
    end else begin
      if (tick) begin
        ptr_q <= ptr_nxt;
        for (int i = 0; i < NUM_CH; i++) begin
          if (ptr_q == CH_W'(i)) current_q[i] <= svc_next;
        end
      end
      if (wr_en && ch_valid(wr_ch)) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_ch == CH_W'(i)) target_q[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    gain_out = '0;
    busy     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      gain_out[GAIN_W*i +: GAIN_W] = current_q[i];
      busy = busy | (current_q[i] != target_q[i]);
    end
  end

endmodule

// File: tb/tb_mixer_gain_ramp.sv
module tb_mixer_gain_ramp;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [7:0]  wr_data;
  logic [3:0]  ramp_step;
  logic        kill;
  logic [47:0] gain_out;
  logic        busy;

  int tests;
  int fails;

  mixer_gain_ramp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_data   (wr_data),
    .ramp_step (ramp_step),
    .kill      (kill),
    .gain_out  (gain_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [7:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_data = d;
    step_clk();
    wr_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step_clk();
    tick = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    tick = 0; wr_en = 0; wr_ch = 0; wr_data = 0; ramp_step = 0; kill = 0;
    rst_n = 1'b0;
    #12;
    chk("rst_gain", gain_out, 48'h0);
    chk("rst_busy", {47'h0, busy}, 48'h0);
    @(negedge clk); rst_n = 1'b1;
    step_clk();

    // Ramp ch3 to 0x40 at step 4
    ramp_step = 4'd4;
    wr(3'd3, 8'h40);
    chk("ramp_busy_start", {47'h0, busy}, 48'h1);
    chk("ramp_gain_start", gain_out, 48'h0);
    tick = 1'b1;
    for (int g = 0; g < 16; g++) begin
      for (int t = 0; t < 6; t++) begin
        step_clk();
        if (t == 2) chk("ramp_pre_svc", {40'h0, gain_out[31:24]}, 48'(4 * g));
        if (t == 3) chk("ramp_post_svc", {40'h0, gain_out[31:24]}, 48'(4 * (g + 1)));
      end
      chk("ramp_busy", {47'h0, busy}, (g < 15) ? 48'h1 : 48'h0);
    end
    tick = 1'b0;
    chk("ramp_final", gain_out, 48'h0000_4000_0000);

    // Jump ch0 to 0x0A, then ramp to 0 with step 15 (no wrap)
    ramp_step = 4'd0;
    wr(3'd0, 8'h0A);
    ticks(1);
    chk("jump_ch0", gain_out, 48'h0000_4000_000A);
    ramp_step = 4'd15;
    wr(3'd0, 8'h00);
    ticks(5);
    chk("no_svc_hold", gain_out, 48'h0000_4000_000A);
    ticks(1);
    chk("floor_zero", gain_out, 48'h0000_4000_0000);
    chk("floor_busy", {47'h0, busy}, 48'h0);

    // Step 0 jump on ch5
    ramp_step = 4'd0;
    wr(3'd5, 8'hC0);
    ticks(4);
    chk("jump_ch5_wait", gain_out, 48'h0000_4000_0000);
    ticks(1);
    chk("jump_ch5", gain_out, 48'hC000_4000_0000);
    chk("jump_ch5_busy", {47'h0, busy}, 48'h0);

    // Write and tick on ch0 in the same cycle
    wr(3'd0, 8'h10);
    ramp_step = 4'd8;
    tick = 1'b1; wr_en = 1'b1; wr_ch = 3'd0; wr_data = 8'h80;
    step_clk();
    tick = 1'b0; wr_en = 1'b0;
    chk("coll_old_tgt", gain_out, 48'hC000_4000_0008);
    ticks(12);
    chk("coll_new_tgt", gain_out, 48'hC000_4000_0018);
    chk("coll_busy", {47'h0, busy}, 48'h1);

    // All channels mid-ramp, then kill with tick and write
    wr(3'd1, 8'h20);
    wr(3'd2, 8'h30);
    wr(3'd3, 8'h90);
    wr(3'd4, 8'h50);
    wr(3'd5, 8'h10);
    ramp_step = 4'd1;
    ticks(6);
    chk("mid_ramp_all", gain_out, 48'hBF01_4101_0119);
    kill = 1'b1; tick = 1'b1; wr_en = 1'b1; wr_ch = 3'd1; wr_data = 8'hAA;
    step_clk();
    kill = 1'b0; tick = 1'b0; wr_en = 1'b0;
    chk("kill_gain", gain_out, 48'h0);
    chk("kill_busy", {47'h0, busy}, 48'h0);
    ramp_step = 4'd0;
    wr(3'd1, 8'h33);
    ticks(1);
    chk("kill_ptr_kept", gain_out, 48'h0000_0000_3300);

    // Writes to channels 6 and 7 are ignored
    wr(3'd7, 8'hFF);
    wr(3'd6, 8'hEE);
    chk("ignore_ch_busy", {47'h0, busy}, 48'h0);
    ticks(6);
    chk("ignore_ch_gain", gain_out, 48'h0000_0000_3300);

    // Reset mid-ramp
    ramp_step = 4'd1;
    wr(3'd2, 8'h80);
    ticks(1);
    chk("pre_rst_ramp", gain_out, 48'h0000_0001_3300);
    tick = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gain", gain_out, 48'h0);
    chk("async_rst_busy", {47'h0, busy}, 48'h0);
    @(negedge clk);
    tick = 1'b0;
    rst_n = 1'b1;
    step_clk();
    chk("post_rst_busy", {47'h0, busy}, 48'h0);
    ticks(6);
    chk("post_rst_gain", gain_out, 48'h0);
    ramp_step = 4'd0;
    wr(3'd0, 8'h22);
    ticks(1);
    chk("post_rst_ptr", gain_out, 48'h0000_0000_0022);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
